// File: rtl/sorter_pkg.sv
// Shared types for the sorting datapath: block control word and sequencer state encodings.
package sorter_pkg;

  typedef struct packed {
    logic sign_ctrl;
  } ctrl_t;

  typedef enum logic [1:0] {
    LOAD,
    SORT,
    DRAIN
  } cas_seq_state_e;

  typedef enum logic {
    PH_EVEN,
    PH_ODD
  } phase_e;

endpackage

// File: rtl/cas.sv
// Registered compare-and-swap: y1 = min, y2 = max, one cycle after the pair is presented.
// Swaps only on strict greater-than so equal keys keep their order; swap pulses for issued pairs.
module cas
  import sorter_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  ctrl_t                ctrl,
  input  logic [DATAWIDTH-1:0] x1,
  input  logic [DATAWIDTH-1:0] x2,
  output logic [DATAWIDTH-1:0] y1,
  output logic [DATAWIDTH-1:0] y2,
  output logic                 swap
);

  logic gt;

  always_comb begin
    if (ctrl.sign_ctrl) gt = $signed(x1) > $signed(x2);
    else                gt = x1 > x2;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      y1   <= '0;
      y2   <= '0;
      swap <= 1'b0;
    end else begin
      y1   <= gt ? x2 : x1;
      y2   <= gt ? x1 : x2;
      swap <= en & gt;
    end
  end

endmodule

// File: rtl/cas_sort_seq.sv
// Loads N_ELEM words, odd-even transposition sorts them through one registered cas, drains smallest first.
// SORT takes (N/2)(N+1) cycles; input stalls outside LOAD, DRAIN holds data while out_ready_i is low.
module cas_sort_seq
  import sorter_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int N_ELEM    = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  ctrl_t                ctrl_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DATAWIDTH-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DATAWIDTH-1:0] out_data_o,
  output logic                 out_last_o,
  output ctrl_t                ctrl_o,
  output logic                 busy_o
);

  if (N_ELEM < 4 || (N_ELEM % 2) != 0) begin : g_bad_n_elem
    $error("cas_sort_seq: N_ELEM must be even and >= 4");
  end

  localparam int             CW   = $clog2(N_ELEM);
  localparam logic [CW-1:0]  LAST = CW'(N_ELEM - 1);
  localparam logic [CW-1:0]  HALF = CW'(N_ELEM / 2);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  cas_seq_state_e state, state_nxt;
  phase_e         ph;

  logic [CW-1:0]        load_cnt, drain_cnt, phase_cnt, pair_cnt;
  logic [CW-1:0]        lo, lo_p1, wb_lo, wb_lo_p1, bubble_idx;
  logic                 wb_vld, issue, phase_end, in_acc, out_acc;
  ctrl_t                ctrl_q;
  logic [DATAWIDTH-1:0] mem [N_ELEM];
  logic [DATAWIDTH-1:0] y1, y2;
  logic                 swap;

  assign in_ready_o  = (state == LOAD) && rstn_i;
  assign in_acc      = in_valid_i && in_ready_o;
  assign out_valid_o = (state == DRAIN);
  assign out_acc     = out_valid_o && out_ready_i;
  assign out_data_o  = out_valid_o ? mem[drain_cnt] : '0;
  assign out_last_o  = out_valid_o && (drain_cnt == LAST);
  assign busy_o      = (state != LOAD);
  assign ctrl_o      = ctrl_q;

  // The slot after the last pair of a phase is the bubble that lets the final write-back land.
  assign bubble_idx = (ph == PH_EVEN) ? HALF : HALF - ONE;
  assign issue      = (state == SORT) && (pair_cnt != bubble_idx);
  assign phase_end  = (state == SORT) && (pair_cnt == bubble_idx);
  assign lo         = {pair_cnt[CW-2:0], ph == PH_ODD};
  assign lo_p1      = lo + ONE;
  assign wb_lo_p1   = wb_lo + ONE;

  cas #(
    .DATAWIDTH(DATAWIDTH)
  ) u_cas (
    .clk  (clk_i),
    .rstn (rstn_i),
    .en   (issue),
    .ctrl (ctrl_q),
    .x1   (mem[lo]),
    .x2   (mem[lo_p1]),
    .y1   (y1),
    .y2   (y2),
    .swap (swap)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_acc && load_cnt == LAST)        state_nxt = SORT;
      SORT:    if (phase_end && phase_cnt == LAST)    state_nxt = DRAIN;
      DRAIN:   if (out_acc && drain_cnt == LAST)      state_nxt = LOAD;
      default:                                        state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= LOAD;
      ph        <= PH_EVEN;
      load_cnt  <= '0;
      drain_cnt <= '0;
      phase_cnt <= '0;
      pair_cnt  <= '0;
      wb_vld    <= 1'b0;
      wb_lo     <= '0;
      ctrl_q    <= '0;
      for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
    end else begin
      state  <= state_nxt;
      wb_vld <= issue;
      wb_lo  <= lo;

      if (in_acc) begin
        mem[load_cnt] <= in_data_i;
        load_cnt      <= (load_cnt == LAST) ? '0 : load_cnt + ONE;
        if (load_cnt == '0) ctrl_q <= ctrl_i;
      end

      if (wb_vld) begin
        mem[wb_lo]    <= y1;
        mem[wb_lo_p1] <= y2;
      end

      if (phase_end) begin
        pair_cnt  <= '0;
        ph        <= (ph == PH_EVEN) ? PH_ODD : PH_EVEN;
        phase_cnt <= (phase_cnt == LAST) ? '0 : phase_cnt + ONE;
      end else if (issue) begin
        pair_cnt <= pair_cnt + ONE;
      end

      if (out_acc) drain_cnt <= (drain_cnt == LAST) ? '0 : drain_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_cas_sort_seq.sv
// Directed-vector bench for cas_sort_seq with a queue scoreboard and an independent output monitor.
module tb_cas_sort_seq;
  import sorter_pkg::*;

  typedef logic [7:0] blk_t [8];
  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       sgn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  ctrl_t      ctrl_i;
  logic       in_valid, in_ready;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last, busy;
  logic [7:0] out_data;
  ctrl_t      ctrl_o;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   swaps = 0;
  bit   count_swaps = 0;
  bit   rdy_rand = 0;
  bit   no_ready_chk = 0;
  exp_t exp_q[$];

  cas_sort_seq #(.DATAWIDTH(8), .N_ELEM(8)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .ctrl_i      (ctrl_i),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .ctrl_o      (ctrl_o),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, checks stalled data against the head.
  always @(negedge clk) begin
    if (count_swaps && dut.u_cas.swap) swaps++;
    if (no_ready_chk) chk("in_ready_low_while_busy", in_ready, 1'b0);
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 1'b1, 1'b0);
      end else if (!out_ready) begin
        chk("stall_data", out_data, exp_q[0].d);
      end else begin
        chk("out_data", out_data, exp_q[0].d);
        chk("out_last", out_last, exp_q[0].last);
        chk("ctrl_o", ctrl_o.sign_ctrl, exp_q[0].sgn);
        if (exp_q[0].last) no_ready_chk = 0;
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_block(input blk_t vals, input blk_t srt, input logic sgn,
                            input bit gaps, input bit push);
    int w;
    if (push)
      for (int i = 0; i < 8; i++) exp_q.push_back('{srt[i], i == 7, sgn});
    ctrl_i.sign_ctrl = sgn;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = vals[i];
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 300) begin
        w++;
        @(negedge clk);
      end
      if (!in_ready) chk("load_accept_timeout", 1'b0, 1'b1);
      if (i == 7) last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      // Flipping ctrl after the first accept must not affect this block.
      if (i == 0) ctrl_i.sign_ctrl = ~sgn;
    end
    in_valid = 1'b0;
    no_ready_chk = 1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_complete", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; ctrl_i = '0;

    @(negedge clk);
    chk("rst_in_ready_gated", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_ctrl_o", ctrl_o, '0);
    @(posedge clk);
    #1;

    // Unsigned block plus first-output latency.
    load_block('{8'd5, 8'd3, 8'd200, 8'd0, 8'd7, 8'd7, 8'd1, 8'd255},
               '{8'd0, 8'd1, 8'd3, 8'd5, 8'd7, 8'd7, 8'd200, 8'd255}, 1'b0, 0, 1);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    chk("t1_valid_seen", ok, 1'b1);
    chk("t1_latency", cyc - last_acc_cyc, 37);
    wait_drain();

    // Signed block.
    load_block('{8'h80, 8'h7F, 8'hFF, 8'h01, 8'h00, 8'hC0, 8'h10, 8'h81},
               '{8'h80, 8'h81, 8'hC0, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h7F}, 1'b1, 0, 1);
    wait_drain();

    // Reverse order, input gaps, random downstream stalls, junk input while busy.
    rdy_rand = 1; swaps = 0; count_swaps = 1;
    load_block('{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
               '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 1, 1);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    rdy_rand = 0; count_swaps = 0;
    chk("t3_swaps_seen", swaps != 0, 1'b1);

    // Reset at SORT cycle 10 discards the block.
    load_block('{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9},
               '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9}, 1'b0, 0, 0);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rstn = 1'b0;
    no_ready_chk = 0;
    @(negedge clk);
    chk("t4_in_ready_gated", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("t4_in_ready", in_ready, 1'b1);
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    load_block('{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5},
               '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 1'b0, 0, 1);
    wait_drain();

    // Back-to-back: same values, unsigned then signed.
    load_block('{8'h90, 8'h10, 8'hF0, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h20},
               '{8'h00, 8'h01, 8'h10, 8'h20, 8'h7F, 8'h80, 8'h90, 8'hF0}, 1'b0, 0, 1);
    load_block('{8'h90, 8'h10, 8'hF0, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h20},
               '{8'h80, 8'h90, 8'hF0, 8'h00, 8'h01, 8'h10, 8'h20, 8'h7F}, 1'b1, 0, 1);
    wait_drain();

    // All keys equal: a stable sort never swaps.
    swaps = 0; count_swaps = 1;
    load_block('{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05},
               '{8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05}, 1'b1, 0, 1);
    wait_drain();
    count_swaps = 0;
    chk("t6_no_swaps", swaps, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cas_sort_seq.md
Name: cas_sort_seq

Overview:
- Sequencer that sorts a block of N_ELEM words in ascending order by time-multiplexing one cas compare-and-swap unit.
- Runs odd-even transposition sort over an internal register buffer.
- Loads a block through a valid/ready input stream, sorts it in place, then drains it through a valid/ready output stream.
- Sits between the upstream sample source and top-k selection logic.

Parameters:
- DATAWIDTH, 8, element width in bits.
- N_ELEM, 8, elements per block. Must be even and >= 4; elaboration error otherwise.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.
- ctrl_i  in  ctrl_t  sort control, including sign_ctrl (0 unsigned, 1 signed). Sampled with the first accepted element of a block.
- in_valid_i  in  1  input element valid.
- in_ready_o  out  1  block accepts input (LOAD state only).
- in_data_i  in  DATAWIDTH  input element.
- out_valid_o  out  1  sorted element valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DATAWIDTH  sorted element, smallest first.
- out_last_o  out  1  high with element N_ELEM-1.
- ctrl_o  out  ctrl_t  latched block control, stable from first accept until last output.
- busy_o  out  1  high in SORT and DRAIN.

Behaviour:
- Reset: one clock, synchronous, active-low. While rstn_i is low on a clock edge:
  - state goes to LOAD; counters and buffer are cleared.
  - out_valid_o, out_last_o, busy_o = 0; out_data_o = 0; ctrl_o = all-zero.
  - in_ready_o is gated to 0 while rstn_i is low.
  - The cas instance is reset from the same rstn_i.
- LOAD:
  - in_ready_o = 1.
  - Each in_valid_i && in_ready_o writes buf[load_cnt] and increments load_cnt; gaps in in_valid_i are allowed.
  - The first accept latches ctrl_i.
  - The accept of element N_ELEM-1 moves to SORT next cycle.
- SORT: N_ELEM phases, alternating EVEN, ODD, EVEN, ...
  - EVEN phase: pairs (0,1), (2,3), ... (N-2,N-1).
  - ODD phase: pairs (1,2), ... (N-3,N-2).
  - One pair is issued to cas per cycle: x1 = buf[lo], x2 = buf[lo+1], with the latched ctrl.
  - cas output is registered (1-cycle latency). The result is written to buf[lo] (y1) and buf[lo+1] (y2) at the end of the cycle after issue.
  - Each phase ends with one bubble cycle (no issue) so the next phase never reads a stale element.
  - Cycles per phase: EVEN = N/2+1, ODD = N/2. Total SORT = (N/2)(N+1) cycles; 36 for N=8.
  - After the final bubble, go to DRAIN.
- DRAIN:
  - out_valid_o = 1 and out_data_o = buf[drain_cnt] (registered view, stable while stalled).
  - Advance on out_valid_o && out_ready_i.
  - out_last_o = (drain_cnt == N_ELEM-1).
  - After the last handshake, go to LOAD next cycle with in_ready_o = 1.
- Ordering and comparison:
  - Equal keys keep arrival order (stable), because cas swaps only on strict greater-than.
  - Signed/unsigned selection follows the latched ctrl for the whole block.
- Boundary conditions:
  - in_valid_i during SORT/DRAIN is ignored.
  - ctrl_i changes after the first accept have no effect until the next block.
  - Reset mid-SORT or mid-DRAIN discards the block; no partial output is emitted.
  - out_ready_i held low stalls DRAIN indefinitely with no data change.
  - load_cnt and drain_cnt are $clog2(N_ELEM) bits and wrap to 0 at block end.

Decomposition:
- sorter_pkg gains:
  - cas_seq_state_e enum {LOAD, SORT, DRAIN}.
  - A phase enum {PH_EVEN, PH_ODD}.
- ctrl_t is reused from sorter_pkg unchanged.
- One sub-module: the existing cas, instantiated with DATAWIDTH passed through.
- Buffer, counters and FSM stay in cas_sort_seq.

Test Plan:
1. Unsigned block: ctrl sign_ctrl=0, load 5,3,200,0,7,7,1,255 with out_ready_i=1 and last accept at cycle t.
   - out_valid_o first high at t+37.
   - Outputs 0,1,3,5,7,7,200,255; out_last_o high only on 255.
2. Signed block: sign_ctrl=1, load 0x80,0x7F,0xFF,0x01,0x00,0xC0,0x10,0x81.
   - Outputs 0x80,0x81,0xC0,0xFF,0x00,0x01,0x10,0x7F.
3. Reverse-sorted input 8..1 with random in_valid_i gaps and out_ready_i toggling 50%.
   - Outputs 1..8 in order; out_data_o stable whenever out_ready_i=0.
   - in_ready_o=0 from SORT entry through the last output.
4. rstn_i low for one cycle at SORT cycle 10.
   - Next cycle: in_ready_o=1, out_valid_o=0, busy_o=0.
   - A new block 4,3,2,1,8,7,6,5 sorts to 1..8 with no stale data emitted.
5. Back-to-back blocks: second block accepted the cycle after the first block's out_last handshake.
   - Each block uses its own latched sign_ctrl (first unsigned, second signed); ctrl_o matches per block.
6. Stability: load 0x05 tagged in order A..H with all keys equal (tags via a reference model on equal values).
   - Output order equals input order; no swaps observed at the cas y outputs.
